// File: rtl/opc7_mem_bridge.sv
// opc7_mem_bridge: turns opc7 CPU bus cycles into either four byte accesses
// on an 8-bit asynchronous SRAM or one 32-bit req/ack I/O transfer. The CPU
// is held off with clken while a transfer is in flight.
module opc7_mem_bridge #(
    parameter int WAIT_STATES = 1,   // strobe cycles per SRAM byte (1..15)
    parameter int IO_TIMEOUT  = 255  // cycles allowed for io_ack (1..255)
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        vpa,
    input  logic        vda,
    input  logic        vio,
    input  logic [19:0] address,
    input  logic        rnw,
    input  logic [31:0] dout,
    output logic [31:0] din,
    output logic        clken,
    output logic [21:0] mem_addr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    output logic        mem_ce_b,
    output logic        mem_oe_b,
    output logic        mem_we_b,
    output logic [19:0] io_addr,
    output logic [31:0] io_wdata,
    output logic        io_rnw,
    output logic        io_req,
    input  logic        io_ack,
    input  logic [31:0] io_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        IO   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] WS_LAST  = 4'(WAIT_STATES);
    localparam logic [7:0] TOUT_END = 8'(IO_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [3:0]  wait_q, wait_d;
    logic [7:0]  tout_q, tout_d;
    logic [31:0] din_q, din_d;

    // The IDLE cycle in which a memory request first appears already acts as
    // cycle 0 of lane 0 (lane/wait counters are always zero in IDLE), so the
    // CPU sees exactly 4*(WAIT_STATES+1) stalled cycles before DONE.
    logic mem_start;
    logic mem_busy;
    logic mem_act;
    logic io_act;
    logic lane_last;

    assign mem_start = (state_q == IDLE) && !vio && (vpa || vda);
    assign mem_busy  = mem_start || (state_q == MEM);
    assign lane_last = (wait_q == WS_LAST);
    // Strobes are gated by reset_b so a reset drops them without a clock edge.
    assign mem_act   = reset_b && mem_busy;
    assign io_act    = reset_b && (state_q == IO);

    // State and datapath registers; reset abandons any transfer in progress.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
            lane_q  <= 2'd0;
            wait_q  <= 4'd0;
            tout_q  <= 8'd0;
            din_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            wait_q  <= wait_d;
            tout_q  <= tout_d;
            din_q   <= din_d;
        end
    end

    // Next-state, counter and read-data assembly.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        wait_d  = wait_q;
        tout_d  = tout_q;
        din_d   = din_q;

        case (state_q)
            IDLE: begin
                lane_d = 2'd0;
                wait_d = 4'd0;
                tout_d = 8'd0;
                if (vio) begin
                    state_d = IO;
                end
            end
            MEM: ;
            IO: begin
                // An ack arriving on the timeout cycle still delivers real data.
                if (io_ack) begin
                    if (rnw) begin
                        din_d = io_rdata;
                    end
                    state_d = DONE;
                end else if (tout_q == TOUT_END) begin
                    if (rnw) begin
                        din_d = 32'hFFFF_FFFF;
                    end
                    state_d = DONE;
                end else begin
                    tout_d = tout_q + 8'd1;
                end
            end
            DONE: begin
                lane_d  = 2'd0;
                wait_d  = 4'd0;
                tout_d  = 8'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Byte-lane sequencing, shared by the decode cycle and MEM.
        if (mem_busy) begin
            if (lane_last) begin
                if (rnw) begin
                    din_d[{lane_q, 3'b000} +: 8] = mem_din;
                end
                wait_d  = 4'd0;
                lane_d  = lane_q + 2'd1;
                state_d = (lane_q == 2'd3) ? DONE : MEM;
            end else begin
                wait_d  = wait_q + 4'd1;
                state_d = MEM;
            end
        end
    end

    // Bus-facing outputs, decoded from the current state and the live CPU bus.
    always_comb begin
        clken    = !reset_b || (state_q == DONE) ||
                   ((state_q == IDLE) && !(vio || vpa || vda));
        din      = din_q;

        mem_ce_b = !mem_act;
        mem_oe_b = !(mem_act && rnw);
        // Write strobe low for the first WAIT_STATES cycles, high on the hold cycle.
        mem_we_b = !(mem_act && !rnw && (wait_q < WS_LAST));
        mem_addr = mem_act ? {address, lane_q} : 22'd0;
        mem_dout = (mem_act && !rnw) ? dout[{lane_q, 3'b000} +: 8] : 8'd0;

        io_req   = io_act;
        io_addr  = io_act ? address : 20'd0;
        io_wdata = io_act ? dout : 32'd0;
        io_rnw   = io_act ? rnw : 1'b1;
    end

endmodule
